dpll_divider_ctrl: RTL and testbench
====================================

# dpll_divider_ctrl

Loop controller for the DPLL's programmable clock divider. It integrates single-cycle up/down pulses from the phase detector in a K-counter and converts each K-counter overflow into a ±1 step of the divide ratio N. It applies ratio changes only at the divider's wrap boundary so the divided clock never glitches. It also runs an acquire/track lock state machine and reports lock status to the rest of the loop.

## Interface
- N_W, 4: width of the divide ratio N.
- N_NOM, 6: ratio driven at reset and in IDLE.
- N_MIN, 3: lowest ratio allowed, inclusive.
- N_MAX, 12: highest ratio allowed, inclusive.
- K_MAX, 8: K-counter overflow magnitude.
- LOCK_CNT, 16: number of consecutive quiet wraps needed to declare lock.
- UNLOCK_MISS, 3: number of ratio changes in TRACK that forces ACQUIRE.
- clk  in  1  system clock (same domain as the divider input clock).
- reset  in  1  asynchronous, active-high.
- enable  in  1  loop enable, level.
- pd_up  in  1  phase-detector "too slow" pulse, one cycle.
- pd_dn  in  1  phase-detector "too fast" pulse, one cycle.
- div_wrap  in  1  one-cycle pulse from the divider when its counter reloads (output toggle).
- div_n  out  N_W  divide ratio driven to the divider, registered.
- div_load  out  1  one-cycle strobe on the cycle div_n takes a new value.
- locked  out  1  high in TRACK.
- saturated  out  1  sticky; set when a step is blocked by N_MIN or N_MAX; cleared in IDLE.
- state  out  2  current FSM state, for debug.

## Operation
- **States:** IDLE, ACQUIRE, TRACK (encodings 0, 1, 2).
- **IDLE:**
  - div_n = N_NOM; K-counter, pending request, quiet count and miss count all cleared.
  - enable=1 moves the FSM to ACQUIRE.
- **enable=0 in ACQUIRE or TRACK:**
  - The FSM goes to IDLE on the next edge.
  - div_n returns to N_NOM on that same edge.
  - div_load pulses on that edge only if div_n actually changed.
- **K-counter:** signed range −K_MAX..+K_MAX, width clog2(K_MAX)+2.
  - pd_up alone adds 1; pd_dn alone subtracts 1; both together, or neither, leaves it unchanged.
  - Reaching +K_MAX raises a pending DEC request (shorter period) and clears the counter to 0 on the same edge.
  - Reaching −K_MAX raises a pending INC request and clears the counter to 0 on the same edge.
- **Pending request:** a single register holding NONE, INC or DEC.
  - A new request in the same direction as the one already pending is dropped.
  - A new request in the opposite direction cancels the pending one, leaving NONE.
- **Applying a request:** at the first div_wrap strictly after the request was registered:
  - INC sets N+1; DEC sets N−1.
  - If the result would leave [N_MIN, N_MAX], N is unchanged, there is no div_load, saturated is set, and the request is discarded without counting as a change.
  - In every case, pending is cleared.
- **Quiet count:** incremented on each div_wrap that applies no change; cleared on each applied change.
  - In ACQUIRE, the quiet count reaching LOCK_CNT moves the FSM to TRACK (locked=1) and clears the miss count.
- **Miss count (TRACK only):**
  - Incremented on each applied change.
  - Cleared when the quiet count reaches LOCK_CNT again.
  - Reaching UNLOCK_MISS moves the FSM to ACQUIRE (locked=0) and clears the quiet count.
- **Off-nominal parameters:** N_NOM outside [N_MIN, N_MAX] is illegal and is flagged by a simulation assertion.

## Timing
- **Reset values:** div_n=N_NOM, div_load=0, locked=0, saturated=0, state=IDLE, all internal counters 0.
- **pd pulse to pending:** a pd pulse sampled at edge t makes the overflow visible in pending after edge t.
- **Request application:** a div_wrap sampled at edge t' > t updates div_n at edge t' and asserts div_load for the cycle after t'. This is 1-cycle latency from div_wrap.
- **Overflow and div_wrap on the same edge:** the divider uses the old pending value; the new request waits for the next wrap.
- **State changes:** locked and state change on the same edge as the transition they reflect.
- **Mid-operation reset:** reset asserted at any time forces all reset values immediately, with no div_load. Deassertion is synchronised externally.

## Structure
- **Shared package dpll_pkg:**
  - state enum, {IDLE, ACQUIRE, TRACK}.
  - request enum, {NONE, INC, DEC}.
  - default parameter constants.
- **Sub-module dpll_k_counter:** the saturating up/down accumulator with overflow flags. Parameter K_MAX; inputs up, dn, clr; outputs ovf_pos, ovf_neg.
- **Top level:** the FSM, pending register, ratio register and lock counters.

## Test plan
- **Reset and enable:** reset, then enable=1 with no pd pulses.
  - div_n=6 throughout; state=ACQUIRE.
  - After 16 wraps, locked=1 and state=TRACK.
- **Single step down:** 8 pd_up pulses, then a div_wrap.
  - div_n goes 6→5; div_load is high for exactly one cycle after the wrap.
  - K-counter back at 0.
- **Cancellation:**
  - pd_up and pd_dn asserted together for 20 cycles leave the K-counter at 0 and div_n=6.
  - A DEC pending followed by an INC overflow before the wrap gives no change at the wrap.
- **Saturation at N_MIN:** three DEC steps take div_n 6→3. A fourth overflow plus wrap leaves div_n=3, gives no div_load, and sets saturated=1.
- **Unlock:** in TRACK, three applied changes cause locked to drop and state=ACQUIRE on the third change's edge.
- **Mid-operation disable and reset:**
  - enable=0 with div_n=9 gives div_n=6, div_load=1 and state=IDLE on the next edge.
  - Async reset mid-ACQUIRE clears everything immediately.

Source files
------------

// File: rtl/dpll_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg
// Shared types and default constants for the DPLL divider loop controller.
//   state_t : lock state machine encoding (IDLE=0, ACQUIRE=1, TRACK=2)
//   req_t   : pending ratio-step request (NONE, INC, DEC)
//   DEF_*   : default parameter values used by the controller
//   req_merge() : combines a held request with a newly raised one
// ---------------------------------------------------------------------------
package dpll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } req_t;

  localparam int DEF_N_W         = 4;
  localparam int DEF_N_NOM       = 6;
  localparam int DEF_N_MIN       = 3;
  localparam int DEF_N_MAX       = 12;
  localparam int DEF_K_MAX       = 8;
  localparam int DEF_LOCK_CNT    = 16;
  localparam int DEF_UNLOCK_MISS = 3;

  // A repeat of the held direction is dropped; the opposite direction
  // cancels the held request so the two overflows net out to nothing.
  function automatic req_t req_merge(input req_t held, input req_t incoming);
    req_t result;
    result = held;
    if (incoming != NONE) begin
      if (held == NONE) begin
        result = incoming;
      end else if (held != incoming) begin
        result = NONE;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/dpll_divider_ctrl_if.sv
// ---------------------------------------------------------------------------
// dpll_divider_ctrl_if
// Bundles the loop-side signals of the divider controller.
//   enable    : loop enable level
//   pd_up     : phase-detector "too slow" pulse
//   pd_dn     : phase-detector "too fast" pulse
//   div_wrap  : divider reload pulse
//   div_n     : divide ratio to the divider
//   div_load  : strobe when div_n takes a new value
//   locked    : loop is in TRACK
//   saturated : sticky flag, a step hit a ratio limit
//   state     : FSM state for debug
// Modports: master drives the loop inputs, slave is the controller.
// ---------------------------------------------------------------------------
interface dpll_divider_ctrl_if #(
  parameter int N_W = 4
) ();

  logic           enable;
  logic           pd_up;
  logic           pd_dn;
  logic           div_wrap;
  logic [N_W-1:0] div_n;
  logic           div_load;
  logic           locked;
  logic           saturated;
  logic [1:0]     state;

  modport master (
    output enable, pd_up, pd_dn, div_wrap,
    input  div_n, div_load, locked, saturated, state
  );

  modport slave (
    input  enable, pd_up, pd_dn, div_wrap,
    output div_n, div_load, locked, saturated, state
  );

endinterface

// File: rtl/dpll_k_counter.sv
// ---------------------------------------------------------------------------
// dpll_k_counter
// Signed up/down accumulator for phase-detector pulses. When the count would
// reach +K_MAX or -K_MAX the matching overflow flag fires combinationally for
// that cycle and the count returns to 0 on the same edge.
//   clk, reset : clock, async active-high reset
//   up, dn     : single-cycle pulses; both or neither hold the count
//   clr        : synchronous clear, also suppresses overflow flags
//   ovf_pos    : count reaches +K_MAX this edge
//   ovf_neg    : count reaches -K_MAX this edge
// ---------------------------------------------------------------------------
module dpll_k_counter #(
  parameter int K_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic dn,
  input  logic clr,
  output logic ovf_pos,
  output logic ovf_neg
);

  localparam int KW = $clog2(K_MAX) + 2;
  localparam logic signed [KW-1:0] K_TOP = KW'(K_MAX - 1);
  localparam logic signed [KW-1:0] K_BOT = KW'(1 - K_MAX);

  logic signed [KW-1:0] count;
  logic                 step_up;
  logic                 step_dn;

  // Simultaneous up and dn cancel each other before anything is counted.
  assign step_up = up && !dn;
  assign step_dn = dn && !up;

  // The overflow is flagged on the edge that would land on the limit, so the
  // stored count never actually holds +/-K_MAX.
  assign ovf_pos = !clr && step_up && (count == K_TOP);
  assign ovf_neg = !clr && step_dn && (count == K_BOT);

  // Accumulator: clear has priority, an overflow restarts from zero,
  // otherwise follow the net pulse direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || ovf_pos || ovf_neg) begin
      count <= '0;
    end else if (step_up) begin
      count <= count + KW'(1);
    end else if (step_dn) begin
      count <= count - KW'(1);
    end
  end

endmodule

// File: rtl/dpll_divider_ctrl.sv
// ---------------------------------------------------------------------------
// dpll_divider_ctrl
// Loop controller for the DPLL programmable divider. Integrates phase-detector
// pulses in a K-counter, turns each overflow into a pending +/-1 ratio step,
// applies the step only at a divider wrap, and runs the acquire/track lock FSM.
//   clk, reset : clock, async active-high reset
//   bus        : dpll_divider_ctrl_if.slave (enable, pd_up, pd_dn, div_wrap in;
//                div_n, div_load, locked, saturated, state out)
// ---------------------------------------------------------------------------
module dpll_divider_ctrl
  import dpll_pkg::*;
#(
  parameter int N_W         = DEF_N_W,
  parameter int N_NOM       = DEF_N_NOM,
  parameter int N_MIN       = DEF_N_MIN,
  parameter int N_MAX       = DEF_N_MAX,
  parameter int K_MAX       = DEF_K_MAX,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int UNLOCK_MISS = DEF_UNLOCK_MISS
) (
  input logic               clk,
  input logic               reset,
  dpll_divider_ctrl_if.slave bus
);

  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_MISS + 1);

  localparam logic [N_W-1:0] N_NOM_V    = N_W'(N_NOM);
  localparam logic [N_W-1:0] N_MIN_V    = N_W'(N_MIN);
  localparam logic [N_W-1:0] N_MAX_V    = N_W'(N_MAX);
  localparam logic [QW-1:0]  LOCK_V     = QW'(LOCK_CNT);
  localparam logic [QW-1:0]  LOCK_LAST  = QW'(LOCK_CNT - 1);
  localparam logic [MW-1:0]  MISS_LAST  = MW'(UNLOCK_MISS - 1);

  state_t         state_q;
  req_t           pending_q;
  logic [N_W-1:0] div_n_q;
  logic           div_load_q;
  logic           locked_q;
  logic           saturated_q;
  logic [QW-1:0]  quiet_q;
  logic [MW-1:0]  miss_q;

  logic active;
  logic k_clr;
  logic ovf_pos;
  logic ovf_neg;
  logic wrap;
  logic step_ok;
  logic applied;
  logic blocked;
  logic quiet_wrap;
  logic quiet_hit;
  logic miss_hit;
  req_t k_req;
  req_t pend_next;

  // The loop only integrates while running and enabled; a disable edge
  // clears the counter together with everything else.
  assign active = (state_q != IDLE) && bus.enable;
  assign k_clr  = !active;

  dpll_k_counter #(
    .K_MAX (K_MAX)
  ) u_kcnt (
    .clk     (clk),
    .reset   (reset),
    .up      (bus.pd_up),
    .dn      (bus.pd_dn),
    .clr     (k_clr),
    .ovf_pos (ovf_pos),
    .ovf_neg (ovf_neg)
  );

  // Decode this cycle's wrap outcome from the request held before the edge.
  // A positive overflow means the divided clock is too slow, so the period
  // shortens (DEC); a negative overflow lengthens it (INC). A request raised
  // on a wrap edge is merged against NONE so it waits for the next wrap.
  always_comb begin
    k_req   = NONE;
    step_ok = 1'b0;
    if (ovf_pos) begin
      k_req = DEC;
    end else if (ovf_neg) begin
      k_req = INC;
    end
    if (pending_q == INC) begin
      step_ok = (div_n_q < N_MAX_V);
    end else if (pending_q == DEC) begin
      step_ok = (div_n_q > N_MIN_V);
    end
    wrap       = active && bus.div_wrap;
    applied    = wrap && (pending_q != NONE) && step_ok;
    blocked    = wrap && (pending_q != NONE) && !step_ok;
    quiet_wrap = wrap && !applied;
    quiet_hit  = quiet_wrap && (quiet_q == LOCK_LAST);
    miss_hit   = applied && (state_q == TRACK) && (miss_q == MISS_LAST);
    pend_next  = req_merge(wrap ? NONE : pending_q, k_req);
  end

  // Lock FSM together with the ratio register, pending request and the
  // quiet/miss counters. Every output is registered here so div_n and
  // div_load change on the same edge as the decision that drives them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= NONE;
      div_n_q     <= N_NOM_V;
      div_load_q  <= 1'b0;
      locked_q    <= 1'b0;
      saturated_q <= 1'b0;
      quiet_q     <= '0;
      miss_q      <= '0;
    end else begin
      div_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_n_q     <= N_NOM_V;
          pending_q   <= NONE;
          quiet_q     <= '0;
          miss_q      <= '0;
          saturated_q <= 1'b0;
          locked_q    <= 1'b0;
          if (bus.enable) begin
            state_q <= ACQUIRE;
          end
        end
        default: begin
          if (!bus.enable) begin
            // Fall back to the nominal ratio; strobe only if it moves.
            state_q     <= IDLE;
            locked_q    <= 1'b0;
            div_n_q     <= N_NOM_V;
            div_load_q  <= (div_n_q != N_NOM_V);
            pending_q   <= NONE;
            quiet_q     <= '0;
            miss_q      <= '0;
            saturated_q <= 1'b0;
          end else begin
            pending_q <= pend_next;
            if (applied) begin
              div_n_q    <= (pending_q == INC) ? div_n_q + N_W'(1)
                                               : div_n_q - N_W'(1);
              div_load_q <= 1'b1;
              quiet_q    <= '0;
            end else if (quiet_wrap && (quiet_q < LOCK_V)) begin
              quiet_q <= quiet_q + QW'(1);
            end
            if (blocked) begin
              saturated_q <= 1'b1;
            end
            if (state_q == ACQUIRE) begin
              if (quiet_hit) begin
                state_q  <= TRACK;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              if (quiet_hit) begin
                miss_q <= '0;
              end else if (applied) begin
                miss_q <= miss_q + MW'(1);
                if (miss_hit) begin
                  state_q  <= ACQUIRE;
                  locked_q <= 1'b0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.div_n     = div_n_q;
  assign bus.div_load  = div_load_q;
  assign bus.locked    = locked_q;
  assign bus.saturated = saturated_q;
  assign bus.state     = state_q;

  // A nominal ratio outside the legal window cannot be driven safely.
  a_nom_legal: assert property (@(posedge clk) disable iff (reset)
    (N_NOM >= N_MIN) && (N_NOM <= N_MAX))
    else $error("N_NOM outside [N_MIN, N_MAX]");

endmodule

// File: tb/tb_dpll_divider_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dpll_divider_ctrl
// Directed, self-checking bench for dpll_divider_ctrl with the default
// parameters (N_NOM=6, N_MIN=3, N_MAX=12, K_MAX=8, LOCK_CNT=16,
// UNLOCK_MISS=3). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so each step observes exactly one edge.
// ---------------------------------------------------------------------------
module tb_dpll_divider_ctrl;
  import dpll_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  dpll_divider_ctrl_if #(.N_W(4)) bus ();

  dpll_divider_ctrl #(
    .N_W         (4),
    .N_NOM       (6),
    .N_MIN       (3),
    .N_MAX       (12),
    .K_MAX       (8),
    .LOCK_CNT    (16),
    .UNLOCK_MISS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Compare every controller output against hand-computed values.
  task automatic checkOutput(input string tag, input int exp_n, input int exp_load,
                             input int exp_locked, input int exp_sat, input int exp_state);
    checkVal({tag, ".div_n"},     32'(bus.div_n),     32'(exp_n));
    checkVal({tag, ".div_load"},  32'(bus.div_load),  32'(exp_load));
    checkVal({tag, ".locked"},    32'(bus.locked),    32'(exp_locked));
    checkVal({tag, ".saturated"}, 32'(bus.saturated), 32'(exp_sat));
    checkVal({tag, ".state"},     32'(bus.state),     32'(exp_state));
  endtask

  // Drive one cycle of inputs, let one edge pass, then drop the pulses.
  task automatic applyStimulus(input logic en, input logic up, input logic dn,
                               input logic wrap);
    bus.enable   = en;
    bus.pd_up    = up;
    bus.pd_dn    = dn;
    bus.div_wrap = wrap;
    @(posedge clk);
    #1;
    bus.pd_up    = 1'b0;
    bus.pd_dn    = 1'b0;
    bus.div_wrap = 1'b0;
  endtask

  task automatic pdPulses(input logic up, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, up, !up, 1'b0);
  endtask

  // One full overflow in the given direction followed by a wrap.
  task automatic stepRatio(input logic up);
    pdPulses(up, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.pd_up    = 1'b0;
    bus.pd_dn    = 1'b0;
    bus.div_wrap = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 6, 0, 0, 0, 0);
    checkVal("reset.kcnt", 32'(dut.u_kcnt.count), 0);
    reset = 1'b0;

    // Enable with no phase error: ACQUIRE, then lock after 16 quiet wraps.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("enable", 6, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 14) checkOutput("wrap15", 6, 0, 0, 0, 1);
    end
    checkOutput("lock", 6, 0, 1, 0, 2);

    // Single step down: 8 up pulses raise DEC, next wrap applies 6->5.
    pdPulses(1'b1, 7);
    checkVal("k7", 32'(dut.u_kcnt.count), 7);
    pdPulses(1'b1, 1);
    checkVal("k_ovf_clear", 32'(dut.u_kcnt.count), 0);
    checkVal("pend_dec", 32'(dut.pending_q), 2);
    checkOutput("ovf_no_change", 6, 0, 1, 0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("step_down", 5, 1, 1, 0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_once", 5, 0, 1, 0, 2);

    // Both pulses together never count.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("both.kcnt", 32'(dut.u_kcnt.count), 0);
    checkVal("both.pend", 32'(dut.pending_q), 0);
    checkOutput("both", 5, 0, 1, 0, 2);

    // DEC pending then an INC overflow cancels; the wrap changes nothing.
    pdPulses(1'b1, 8);
    pdPulses(1'b0, 8);
    checkVal("cancel.pend", 32'(dut.pending_q), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("cancel_wrap", 5, 0, 1, 0, 2);

    // Second and third applied change in TRACK; the third drops lock.
    stepRatio(1'b0);
    checkOutput("unlock1", 6, 1, 1, 0, 2);
    stepRatio(1'b0);
    checkOutput("unlock2", 7, 1, 0, 0, 1);

    // Walk down to N_MIN, then a blocked step sets saturated.
    for (int i = 0; i < 4; i++) begin
      stepRatio(1'b1);
      checkOutput("sat_walk", 6 - i, 1, 0, 0, 1);
    end
    stepRatio(1'b1);
    checkOutput("sat_block", 3, 0, 0, 1, 1);

    // Overflow on the same edge as a wrap waits for the following wrap.
    pdPulses(1'b0, 7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("same_edge", 3, 0, 0, 1, 1);
    checkVal("same_edge.pend", 32'(dut.pending_q), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("same_edge_apply", 4, 1, 0, 1, 1);

    // Raise to 9, then disable: back to 6 with a load strobe.
    for (int i = 0; i < 5; i++) stepRatio(1'b0);
    checkOutput("n9", 9, 1, 0, 1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("disable.div_n", 32'(bus.div_n), 6);
    checkVal("disable.div_load", 32'(bus.div_load), 1);
    checkVal("disable.state", 32'(bus.state), 0);
    checkVal("disable.locked", 32'(bus.locked), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle", 6, 0, 0, 0, 0);

    // Disabling while already at N_NOM gives no strobe.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("disable_nom.div_load", 32'(bus.div_load), 0);
    checkVal("disable_nom.state", 32'(bus.state), 0);

    // Async reset mid-ACQUIRE with a load strobe and a nonzero K-count.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pdPulses(1'b0, 8);
    pdPulses(1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_reset", 7, 1, 0, 0, 1);
    checkVal("pre_reset.kcnt", 32'(dut.u_kcnt.count), 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 6, 0, 0, 0, 0);
    checkVal("async_reset.kcnt", 32'(dut.u_kcnt.count), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
